// File: rtl/onchip_memory_pipelined.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_memory_pipelined
//  Purpose  : Parametrised Avalon-MM slave on-chip RAM with byte-lane writes,
//             pipelined reads (1 or 2 cycles) and optional zero-fill after
//             reset (waitrequest held high until the fill completes).
//  Revision : 1.0 - initial release
// ============================================================================
module onchip_memory_pipelined #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 0,
   parameter     INIT_FILE      = ""
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic                    chipselect,
   input  logic                    clken,
   input  logic                    read,
   input  logic                    write,
   input  logic [DATA_WIDTH-1:0]   writedata,
   output logic                    waitrequest,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readdatavalid
);

   localparam int DEPTH     = 2 ** ADDR_WIDTH;
   localparam int NUM_LANES = DATA_WIDTH / 8;

   // Illegal configurations stop elaboration.
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("onchip_memory_pipelined: READ_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("onchip_memory_pipelined: DATA_WIDTH must be a multiple of 8");
   end

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clear_cnt;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    accept;
   logic                    wr_acc;
   logic                    rd_acc;
   logic                    clearing;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [NUM_LANES-1:0]    mem_be;
   logic [DATA_WIDTH-1:0]   mem_wdata;

   logic                    rd_valid1;
   logic [DATA_WIDTH-1:0]   rd_data1;

   // A simultaneous read+write performs only the write; the read is dropped.
   assign accept   = chipselect & clken & ~waitrequest;
   assign wr_acc   = accept & write;
   assign rd_acc   = accept & read & ~write;
   assign clearing = (state == ST_CLEAR);

   // The fill engine shares the single write port; commands cannot be
   // accepted while it runs because waitrequest is high.
   assign mem_we    = ~reset & clken & (clearing | wr_acc);
   assign mem_addr  = clearing ? clear_cnt : address;
   assign mem_be    = clearing ? {NUM_LANES{1'b1}} : byteenable;
   assign mem_wdata = clearing ? {DATA_WIDTH{1'b0}} : writedata;

   // Control FSM: optional zero-fill sweep after reset, then ready forever.
   always_ff @(posedge clk) begin
      if (reset) begin
         clear_cnt <= '0;
         if (CLEAR_ON_RESET != 0) begin
            state       <= ST_CLEAR;
            waitrequest <= 1'b1;
         end else begin
            state       <= ST_READY;
            waitrequest <= 1'b0;
         end
      end else if (clken) begin
         case (state)
            ST_CLEAR: begin
               clear_cnt <= clear_cnt + ADDR_WIDTH'(1);
               if (clear_cnt == {ADDR_WIDTH{1'b1}}) begin
                  state       <= ST_READY;
                  waitrequest <= 1'b0;
               end
            end
            ST_READY: begin
               waitrequest <= 1'b0;
            end
            default: begin
               state       <= ST_READY;
               waitrequest <= 1'b0;
            end
         endcase
      end
   end

   // Storage array: per-lane write, contents never touched by reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (mem_be[i]) begin
               mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   // First read stage: synchronous array read; data holds between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid1 <= 1'b0;
         rd_data1  <= '0;
      end else if (clken) begin
         rd_valid1 <= rd_acc;
         if (rd_acc) begin
            rd_data1 <= mem[address];
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  rd_valid2;
      logic [DATA_WIDTH-1:0] rd_data2;

      // Extra output register stage, frozen together with the first stage.
      always_ff @(posedge clk) begin
         if (reset) begin
            rd_valid2 <= 1'b0;
            rd_data2  <= '0;
         end else if (clken) begin
            rd_valid2 <= rd_valid1;
            if (rd_valid1) begin
               rd_data2 <= rd_data1;
            end
         end
      end

      assign readdata      = rd_data2;
      assign readdatavalid = rd_valid2;
   end else begin : g_lat1
      assign readdata      = rd_data1;
      assign readdatavalid = rd_valid1;
   end

endmodule
`default_nettype wire

// File: tb/tb_onchip_memory_pipelined.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onchip_memory_pipelined
//  Purpose  : Scoreboard bench for onchip_memory_pipelined. Three instances:
//             d0 defaults, d1 READ_LATENCY=2 / 16 words, d2 CLEAR_ON_RESET=1
//             / 16 words. Expected read data and arrival cycle are queued
//             when a read is driven and popped on each readdatavalid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_memory_pipelined;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [3];
   logic        cs    [3];
   logic        en    [3];
   logic        rd    [3];
   logic        wr    [3];
   logic [9:0]  addr  [3];
   logic [3:0]  be    [3];
   logic [31:0] wdata [3];
   wire  [31:0] rdata [3];
   wire         rdv   [3];
   wire         wreq  [3];

   int lat [3] = '{1, 2, 1};

   onchip_memory_pipelined d0 (
      .clk(clk), .reset(rst[0]), .address(addr[0]), .byteenable(be[0]),
      .chipselect(cs[0]), .clken(en[0]), .read(rd[0]), .write(wr[0]),
      .writedata(wdata[0]), .waitrequest(wreq[0]), .readdata(rdata[0]),
      .readdatavalid(rdv[0]));

   onchip_memory_pipelined #(.ADDR_WIDTH(4), .READ_LATENCY(2)) d1 (
      .clk(clk), .reset(rst[1]), .address(addr[1][3:0]), .byteenable(be[1]),
      .chipselect(cs[1]), .clken(en[1]), .read(rd[1]), .write(wr[1]),
      .writedata(wdata[1]), .waitrequest(wreq[1]), .readdata(rdata[1]),
      .readdatavalid(rdv[1]));

   onchip_memory_pipelined #(.ADDR_WIDTH(4), .CLEAR_ON_RESET(1)) d2 (
      .clk(clk), .reset(rst[2]), .address(addr[2][3:0]), .byteenable(be[2]),
      .chipselect(cs[2]), .clken(en[2]), .read(rd[2]), .write(wr[2]),
      .writedata(wdata[2]), .waitrequest(wreq[2]), .readdata(rdata[2]),
      .readdatavalid(rdv[2]));

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit en_edge [3] = '{1'b0, 1'b0, 1'b0};

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle(input int k);
      cs[k] = 1'b0;
      rd[k] = 1'b0;
      wr[k] = 1'b0;
      be[k] = 4'h0;
   endtask

   task automatic push(input int k, input logic [31:0] d, input int c);
      exp_t e;
      e.data = d;
      e.cyc  = c;
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic set_write(input int k, input int a, input logic [31:0] d,
                            input logic [3:0] b);
      cs[k] = 1'b1; wr[k] = 1'b1; rd[k] = 1'b0;
      addr[k] = 10'(a); wdata[k] = d; be[k] = b;
   endtask

   // Drive a read for the coming edge and queue its expected result.
   task automatic set_read(input int k, input int a, input logic [31:0] d,
                           input int extra);
      cs[k] = 1'b1; rd[k] = 1'b1; wr[k] = 1'b0;
      addr[k] = 10'(a); be[k] = 4'h0;
      push(k, d, cyc + lat[k] + extra);
   endtask

   // Count cycles with waitrequest high; clken is dropped for counts in
   // [gap_lo, gap_hi]. Bounded so a stuck waitrequest cannot hang the run.
   task automatic count_wait(input int k, input int gap_lo, input int gap_hi,
                             output int n);
      n = 0;
      while (wreq[k] && n < 100) begin
         n++;
         en[k] = !(n >= gap_lo && n <= gap_hi);
         tick();
      end
      en[k] = 1'b1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Remember whether each instance advanced at this edge, so a strobe held
   // through clken-low cycles is counted only once.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) en_edge[k] = en[k] | rst[k];
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      for (int k = 0; k < 3; k++) begin
         if (en_edge[k] && rdv[k]) begin
            have = 1'b0;
            case (k)
               0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
               1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
               default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (have) begin
               check_eq($sformatf("d%0d_rdata", k), rdata[k], e.data);
               check_eq($sformatf("d%0d_rdv_cycle", k), cyc, e.cyc);
            end else begin
               check_eq($sformatf("d%0d_unexpected_rdv", k), rdv[k], 0);
            end
         end
      end
   end

   initial begin
      int          n;
      logic [31:0] mdl [8];

      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; en[k] = 1'b1; addr[k] = '0; wdata[k] = '0;
         idle(k);
      end
      repeat (3) tick();
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;

      // Reset state.
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("d%0d_reset_rdv", k), rdv[k], 0);
         check_eq($sformatf("d%0d_reset_rdata", k), rdata[k], 0);
         check_eq($sformatf("d%0d_reset_wreq", k), wreq[k], (k == 2) ? 1 : 0);
      end
      count_wait(2, 0, -1, n);
      check_eq("d2_initial_fill_cycles", n, 16);

      // d0: full write, read-after-write, byte lanes, no-op write.
      set_write(0, 5, 32'hDEADBEEF, 4'hF); tick();
      set_read(0, 5, 32'hDEADBEEF, 0);     tick();
      set_write(0, 5, 32'h11223344, 4'b0101); tick();
      set_read(0, 5, 32'hDE22BE44, 0);     tick();
      set_write(0, 5, 32'h00000000, 4'h0); tick();
      set_read(0, 5, 32'hDE22BE44, 0);     tick();
      // Read+write together: write lands, read is dropped (no queue entry).
      set_write(0, 7, 32'hCAFEF00D, 4'hF);
      rd[0] = 1'b1;                        tick();
      set_read(0, 7, 32'hCAFEF00D, 0);     tick();
      // Back-to-back writes then reads at the top of the address range.
      for (int i = 0; i < 8; i++) begin
         mdl[i] = $urandom;
         set_write(0, 1016 + i, mdl[i], 4'hF); tick();
      end
      for (int i = 0; i < 8; i++) begin
         set_read(0, 1016 + i, mdl[i], 0); tick();
      end
      idle(0);

      // d1 (latency 2): preload and stream eight reads without bubbles.
      for (int i = 0; i < 8; i++) begin
         set_write(1, i, 32'h100 + i, 4'hF); tick();
      end
      for (int i = 0; i < 8; i++) begin
         set_read(1, i, 32'h100 + i, 0); tick();
      end
      idle(1);
      repeat (4) tick();
      // clken low for 3 cycles inside the latency window.
      set_read(1, 3, 32'h103, 3); tick();
      idle(1);
      en[1] = 1'b0;
      repeat (3) tick();
      en[1] = 1'b1;
      repeat (6) tick();
      // Reset the cycle after a read is accepted: the read must vanish.
      cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = 10'd2; tick();
      idle(1);
      rst[1] = 1'b1; tick();
      rst[1] = 1'b0;
      repeat (4) tick();
      check_eq("d1_reset_mid_read_rdata", rdata[1], 0);
      check_eq("d1_reset_mid_read_rdv", rdv[1], 0);

      // d2 (zero-fill): preload, reset, fill with a clken gap, read zeros.
      set_write(2, 3, 32'hFFFFFFFF, 4'hF);  tick();
      set_write(2, 15, 32'hFFFFFFFF, 4'hF); tick();
      set_read(2, 3, 32'hFFFFFFFF, 0);      tick();
      idle(2);
      repeat (2) tick();
      rst[2] = 1'b1; tick();
      rst[2] = 1'b0;
      count_wait(2, 5, 6, n);
      check_eq("d2_fill_cycles_with_gap", n, 18);
      set_read(2, 3, 32'h0, 0);  tick();
      set_read(2, 15, 32'h0, 0); tick();
      idle(2);
      repeat (2) tick();
      // Reset again at counter 7: the fill restarts from address 0.
      rst[2] = 1'b1; tick();
      rst[2] = 1'b0;
      repeat (7) tick();
      check_eq("d2_wreq_mid_fill", wreq[2], 1);
      rst[2] = 1'b1; tick();
      rst[2] = 1'b0;
      count_wait(2, 0, -1, n);
      check_eq("d2_refill_cycles", n, 16);
      set_read(2, 0, 32'h0, 0); tick();
      idle(2);

      repeat (8) tick();
      check_eq("d0_queue_drained", q0.size(), 0);
      check_eq("d1_queue_drained", q1.size(), 0);
      check_eq("d2_queue_drained", q2.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
